// File: rtl/two_to_1_rr_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux.
// Grants are registered. A source can hold the grant for at most MAX_BURST
// cycles while the other source is also requesting. With no competition
// the grant is held indefinitely and burst_cnt wraps.
module two_to_1_rr_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             s0,
   output logic             busy,
   output logic [CNT_W-1:0] burst_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             s0_nxt;
   logic             last;
   logic             last_nxt;

   // State, burst counter, mux select and last-grant pointer registers
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (rst) begin
         state     <= IDLE;
         burst_cnt <= '0;
         s0        <= 1'b0;
         last      <= 1'b1;
      end else begin
         state     <= state_nxt;
         burst_cnt <= cnt_nxt;
         s0        <= s0_nxt;
         last      <= last_nxt;
      end
   end

   // Next-state decision: tie-break on last, hand over at burst end
   always_comb begin
      // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req0 && req1)  state_nxt = last ? G0 : G1;
            else if (req0)     state_nxt = G0;
            else if (req1)     state_nxt = G1;
         end
         G0: begin
            if (!req0)                            state_nxt = req1 ? G1 : IDLE;
            else if (req1 && burst_cnt == LAST_CNT) state_nxt = G1;
         end
         G1: begin
            if (!req1)                            state_nxt = req0 ? G0 : IDLE;
            else if (req0 && burst_cnt == LAST_CNT) state_nxt = G0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of burst counter, select and last-grant pointer
   always_comb begin
      cnt_nxt  = '0;
      s0_nxt   = s0;
      last_nxt = last;
      // Holding the same grant counts up and wraps; any entry or IDLE clears
      if (state_nxt == state && state != IDLE)
         cnt_nxt = (burst_cnt == LAST_CNT) ? '0 : burst_cnt + CNT_W'(1);
      // Select follows the granted source and holds while idle
      if (state_nxt == G0) begin
         s0_nxt   = 1'b0;
         last_nxt = 1'b0;
      end else if (state_nxt == G1) begin
         s0_nxt   = 1'b1;
         last_nxt = 1'b1;
      end
   end

   // Grant outputs decoded from the registered state
   always_comb begin
      gnt0 = (state == G0);
      gnt1 = (state == G1);
      busy = gnt0 | gnt1;
   end

endmodule

// File: tb/tb_two_to_1_rr_arbiter.sv
// Scoreboard bench for two_to_1_rr_arbiter (MAX_BURST=4). The driver applies
// one input vector per cycle and queues the hand-computed outputs expected
// after that edge; the monitor pops and compares after every rising edge.
module tb_two_to_1_rr_arbiter;

   localparam int CNT_W = 4;

   typedef struct {
      logic             gnt0;
      logic             gnt1;
      logic             s0;
      logic             busy;
      logic [CNT_W-1:0] cnt;
      string            tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0 = 1'b0;
   logic             req1 = 1'b0;
   logic             gnt0, gnt1, s0, busy;
   logic [CNT_W-1:0] burst_cnt;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   two_to_1_rr_arbiter #(.MAX_BURST(4), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .req1      (req1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .s0        (s0),
      .busy      (busy),
      .burst_cnt (burst_cnt)
   );

   always #5 clk = ~clk;

   // Drive one vector at the falling edge and queue the post-edge expectation
   task automatic step(input logic r, input logic q0, input logic q1,
                       input logic e_g0, input logic e_g1, input logic e_s0,
                       input int e_cnt, input string tag);
      exp_t e;
      @(negedge clk);
      rst  = r;
      req0 = q0;
      req1 = q1;
      e.gnt0 = e_g0;
      e.gnt1 = e_g1;
      e.s0   = e_s0;
      e.busy = e_g0 | e_g1;
      e.cnt  = CNT_W'(e_cnt);
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every queued expectation just after the rising edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (gnt0 !== e.gnt0 || gnt1 !== e.gnt1 || s0 !== e.s0 ||
             busy !== e.busy || burst_cnt !== e.cnt || (gnt0 & gnt1) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s #%0d: got gnt0=%b gnt1=%b s0=%b busy=%b cnt=%0d, want gnt0=%b gnt1=%b s0=%b busy=%b cnt=%0d",
                     e.tag, vectors, gnt0, gnt1, s0, busy, burst_cnt,
                     e.gnt0, e.gnt1, e.s0, e.busy, e.cnt);
         end
      end
   end

   initial begin
      int wait_cycles;

      // 1: reset with both requests high, then source 0 wins the first tie
      step(1, 1, 1, 0, 0, 0, 0, "reset0");
      step(1, 1, 1, 0, 0, 0, 0, "reset1");
      step(0, 1, 1, 1, 0, 0, 0, "first_tie");
      step(0, 0, 0, 0, 0, 0, 0, "drop_to_idle");

      // 2: req1 alone for 3 cycles; s0 stays 1 while idle afterwards
      step(0, 0, 1, 0, 1, 1, 0, "req1_c0");
      step(0, 0, 1, 0, 1, 1, 1, "req1_c1");
      step(0, 0, 1, 0, 1, 1, 2, "req1_c2");
      step(0, 0, 0, 0, 0, 1, 0, "idle_hold_s0_a");
      step(0, 0, 0, 0, 0, 1, 0, "idle_hold_s0_b");

      // 3: both held for 16 cycles, bursts of 4 alternate with no gap
      for (int i = 0; i < 16; i++) begin
         if (((i / 4) % 2) == 0) step(0, 1, 1, 1, 0, 0, i % 4, "both_g0");
         else                    step(0, 1, 1, 0, 1, 1, i % 4, "both_g1");
      end
      step(0, 0, 0, 0, 0, 1, 0, "both_release");

      // 4: req0 alone for 10 cycles, counter wraps without handover
      for (int i = 0; i < 10; i++)
         step(0, 1, 0, 1, 0, 0, i % 4, "solo_g0_wrap");

      // 5: G0 at burst_cnt=1, drop req0 with req1 high -> direct to G1
      step(0, 0, 1, 0, 1, 1, 0, "handover_no_bubble");

      // 6: reset in G1 at burst_cnt=2, then source 0 wins
      step(0, 0, 1, 0, 1, 1, 1, "g1_c1");
      step(0, 0, 1, 0, 1, 1, 2, "g1_c2");
      step(1, 1, 1, 0, 0, 0, 0, "reset_mid_g1");
      step(0, 1, 1, 1, 0, 0, 0, "after_reset_g0");
      // Reset while G0 holds (last=0): last must return to 1 so G0 wins again
      step(0, 1, 1, 1, 0, 0, 1, "g0_c1");
      step(1, 1, 1, 0, 0, 0, 0, "reset_mid_g0");
      step(0, 1, 1, 1, 0, 0, 0, "last_reset_tie");
      // Release: last-grant pointer now 0, so a new tie goes to source 1
      step(0, 0, 0, 0, 0, 0, 0, "idle_again");
      step(0, 1, 1, 0, 1, 1, 0, "tie_goes_g1");

      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/two_to_1_rr_arbiter.md
Name: two_to_1_rr_arbiter

Overview:
Two-requester round-robin arbiter. It sits directly upstream of two_to_1mux_using_cond_op and drives its select input s0, so that exactly one of the two sources (a0 or a1) is routed to y0 at a time. Grants are registered and bounded by a maximum burst length, so neither source can starve the other.

Parameters:
MAX_BURST, 4, maximum consecutive granted cycles per burst while the other source is requesting (legal range 1..15)
CNT_W, 4, width of burst_cnt; must satisfy 2**CNT_W > MAX_BURST-1

Ports:
clk  input  1  single system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  request from source 0 (mux input a0)
req1  input  1  request from source 1 (mux input a1)
gnt0  output  1  grant to source 0, registered
gnt1  output  1  grant to source 1, registered
s0  output  1  mux select: 0 routes a0 to y0, 1 routes a1 to y0; registered
busy  output  1  high while either grant is high
burst_cnt  output  CNT_W  index of the current granted cycle within the burst, starting at 0

Behaviour:
- One clock; reset is synchronous and active-high. rst has priority over all other inputs.
- Reset values: state=IDLE, gnt0=0, gnt1=0, s0=0, busy=0, burst_cnt=0, internal last-grant pointer last=1 (source 0 wins the first tie).
- States: IDLE, G0, G1. gnt0=(state==G0), gnt1=(state==G1), busy=gnt0|gnt1. All are registered, with no combinational path from req to gnt.
- Latency: a request sampled at edge N produces a grant after edge N. A request dropped at edge N removes the grant after edge N (one trailing cycle).
- IDLE:
  - req0 and req1 both high: grant the source != last.
  - Only one request high: grant that source.
  - Neither high: stay in IDLE.
- G0:
  - req0 low: go to G1 if req1 is high (no idle bubble), else go to IDLE.
  - req0 high, req1 high, burst_cnt==MAX_BURST-1: go to G1.
  - Otherwise stay in G0.
- G1 is symmetric to G0.
- burst_cnt:
  - Cleared to 0 on entry to any G state.
  - Increments each cycle the grant is held.
  - On reaching MAX_BURST-1 with no competing request, the same source stays granted and burst_cnt wraps to 0.
  - Is 0 in IDLE.
- last: updated to the granted source index on every entry into G0 or G1.
- s0: 0 in G0, 1 in G1. In IDLE it holds its previous value, so the mux output does not toggle while idle.
- Invariant: gnt0 & gnt1 is never 1.
- With both requests held continuously, the grant switches without a gap.
- Reset mid-burst: on the next edge every output returns to its reset value regardless of req, and last returns to 1.
- MAX_BURST=1: with both requests held, grants alternate every cycle.

Test Plan:
1. rst=1 for 2 cycles with req0=req1=1 -> gnt0=gnt1=busy=s0=0, burst_cnt=0. Deassert rst -> gnt0=1, s0=0 one cycle later.
2. From idle, req1=1 for 3 cycles, then 0 -> gnt1=1 and s0=1 for exactly 3 cycles, starting one cycle after req1 rises; busy follows gnt1; then IDLE with s0 staying 1 and burst_cnt=0.
3. MAX_BURST=4, req0=req1=1 held for 16 cycles -> gnt0 for 4 cycles (burst_cnt 0,1,2,3), then gnt1 for 4 cycles, repeating. s0 toggles every 4 cycles; there is never a cycle with both grants or with neither.
4. req0=1 alone for 10 cycles -> gnt0 high continuously, burst_cnt 0,1,2,3,0,1,2,3,0,1, s0=0 throughout.
5. In G0 at burst_cnt=1 with req1=1, drop req0 -> next cycle gnt1=1, burst_cnt=0, s0=1, with no IDLE cycle between the grants.
6. In G1 at burst_cnt=2, assert rst for 1 cycle with req0=req1=1 -> next cycle all outputs are 0. After rst deasserts, gnt0 wins first because last was reset to 1.
